alu_mc_sequencer: RTL and testbench

Multi-cycle ALU controller for the RV32I core.
- Accepts one operation plus A/B operands over a valid/ready request channel.
- Sequences the shared combinational logic/arithmetic units (XOR, OR, AND, add/sub, compare).
- Performs shifts iteratively with an internal shift register, avoiding a 32-bit barrel shifter.
- Returns the result over a valid/ready response channel to the core's execute stage.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/Xor32b.sv | 12 +
 rtl/alu_logic_comb.sv | 46 ++++
 rtl/alu_mc_sequencer.sv | 135 +++++++++++++
 tb/tb_alu_mc_sequencer.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the multi-cycle ALU sequencer.
//   XLEN       - operand/result width (RV32I)
//   OP_*       - operation codes {funct7[5], funct3}
//   state_t    - sequencer state encoding
//   is_shift() - true for SLL/SRL/SRA
package alu_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/Xor32b.sv
// Xor32b: 32-bit bitwise XOR.
//   a, b - operands
//   y    - a ^ b
module Xor32b (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  assign y = a ^ b;

endmodule

// File: rtl/alu_logic_comb.sv
// alu_logic_comb: single-cycle ADD/SUB/SLT/SLTU/XOR/OR/AND datapath.
//   op      - operation code
//   a, b    - operands
//   res     - result (0 for shifts and illegal codes)
//   illegal - op is not an RV32I ALU operation
module alu_logic_comb
  import alu_pkg::*;
(
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] res,
  output logic            illegal
);

  logic [XLEN-1:0]        xor_y;
  logic signed [XLEN-1:0] a_s;
  logic signed [XLEN-1:0] b_s;

  assign a_s = a;
  assign b_s = b;

  Xor32b u_xor (
    .a (a),
    .b (b),
    .y (xor_y)
  );

  always_comb begin
    res     = '0;
    illegal = 1'b0;
    case (op)
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_SLT:  res = {{(XLEN-1){1'b0}}, (a_s < b_s)};
      OP_SLTU: res = {{(XLEN-1){1'b0}}, (a < b)};
      OP_XOR:  res = xor_y;
      OP_OR:   res = a | b;
      OP_AND:  res = a & b;
      // Shifts are legal but are produced by the sequencer's shift register.
      OP_SLL, OP_SRL, OP_SRA: res = '0;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_mc_sequencer.sv
// alu_mc_sequencer: multi-cycle ALU controller for the RV32I core.
//   clk, rst_n            - clock (rising edge), async active-low reset
//   req_valid/req_ready   - request handshake carrying op, A, B
//   op                    - {funct7[5], funct3}
//   A, B                  - operands; B[4:0] is the shift amount for shifts
//   resp_valid/resp_ready - response handshake carrying result, resp_err
//   result                - operation result
//   resp_err              - op code was illegal
//   busy                  - high whenever not IDLE
// Shifts run iteratively, SHIFT_STEP bits per cycle (1, 2, 4, 8 or 16).
module alu_mc_sequencer #(
  parameter int SHIFT_STEP = 1,
  parameter int XLEN       = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] result,
  output logic            resp_err,
  output logic            busy
);

  import alu_pkg::*;

  localparam logic [4:0] STEP = 5'(SHIFT_STEP);

  state_t                 state;
  logic [4:0]             cnt;
  logic [3:0]             op_p0;
  logic signed [XLEN-1:0] a_p0;
  logic signed [XLEN-1:0] b_p0;
  logic signed [XLEN-1:0] sh_p0;
  logic [XLEN-1:0]        comb_res;
  logic                   comb_ill;
  logic [4:0]             amt;
  logic [XLEN-1:0]        sh_nxt;
  logic                   accept;

  function automatic logic [XLEN-1:0] shift_by(input logic [3:0] sop,
                                               input logic [XLEN-1:0] val,
                                               input logic [4:0] n);
    case (sop)
      OP_SLL:  return val << n;
      OP_SRA:  return $unsigned($signed(val) >>> n);
      default: return val >> n;
    endcase
  endfunction

  alu_logic_comb u_logic (
    .op      (op_p0),
    .a       (a_p0),
    .b       (b_p0),
    .res     (comb_res),
    .illegal (comb_ill)
  );

  assign accept = req_valid && req_ready;
  // Last partial step shifts only by what remains.
  assign amt    = (cnt < STEP) ? cnt : STEP;
  assign sh_nxt = shift_by(op_p0, sh_p0, amt);

  // Stage p0: operand capture and iterative shift register
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0 <= op;
      a_p0  <= A;
      b_p0  <= B;
      sh_p0 <= A;
    end else if (state == ST_SHIFT) begin
      sh_p0 <= sh_nxt;
    end
  end

  // Control FSM and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      result     <= '0;
      resp_err   <= 1'b0;
      busy       <= 1'b0;
      cnt        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            req_ready <= 1'b0;
            busy      <= 1'b1;
            cnt       <= B[4:0];
            if (is_shift(op) && (B[4:0] != 5'd0)) state <= ST_SHIFT;
            else                                   state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (is_shift(op_p0)) begin
            result <= a_p0;
          end else begin
            result   <= comb_res;
            resp_err <= comb_ill;
          end
          resp_valid <= 1'b1;
          state      <= ST_DONE;
        end
        ST_SHIFT: begin
          if (cnt <= STEP) begin
            cnt        <= '0;
            result     <= sh_nxt;
            resp_valid <= 1'b1;
            state      <= ST_DONE;
          end else begin
            cnt <= cnt - STEP;
          end
        end
        ST_DONE: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc_sequencer.sv
// tb_alu_mc_sequencer: directed self-checking bench for alu_mc_sequencer.
// Two instances: SHIFT_STEP=1 (main) and SHIFT_STEP=4 (shift timing only).
module tb_alu_mc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        vld4;
  logic        resp_ready;
  logic [3:0]  op;
  logic [31:0] A;
  logic [31:0] B;

  logic        req_ready, resp_valid, resp_err, busy;
  logic [31:0] result;
  logic        req_ready_4, resp_valid_4, resp_err_4, busy_4;
  logic [31:0] result_4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_mc_sequencer #(.SHIFT_STEP(1), .XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .op         (op),
    .A          (A),
    .B          (B),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .result     (result),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  alu_mc_sequencer #(.SHIFT_STEP(4), .XLEN(32)) dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (vld4),
    .req_ready  (req_ready_4),
    .op         (op),
    .A          (A),
    .B          (B),
    .resp_valid (resp_valid_4),
    .resp_ready (1'b1),
    .result     (result_4),
    .resp_err   (resp_err_4),
    .busy       (busy_4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    op        = o;
    A         = a;
    B         = b;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  // Steps until resp_valid, bounded; latency reported includes the accept cycle.
  task automatic wait_resp(input string tag, output int lat);
    int n;
    n = 0;
    while (!resp_valid && n < 100) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, {31'b0, resp_valid}, 32'd1);
    lat = n + 1;
  endtask

  initial begin
    int lat;
    int n1;
    int n4;
    int hits;
    logic        seen4;
    logic [31:0] res4;

    rst_n      = 1'b0;
    req_valid  = 1'b0;
    vld4       = 1'b0;
    resp_ready = 1'b1;
    op         = 4'h0;
    A          = 32'h0;
    B          = 32'h0;
    step();
    step();

    // Reset state
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_result", result, 32'h0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    rst_n = 1'b1;
    step();

    // XOR
    issue(4'b0100, 32'hF0F0_1234, 32'h0FF0_FFFF);
    chk("xor_busy", {31'b0, busy}, 32'd1);
    chk("xor_req_ready", {31'b0, req_ready}, 32'd0);
    wait_resp("xor", lat);
    chk("xor_lat", lat, 32'd2);
    chk("xor_result", result, 32'hFF00_EDCB);
    chk("xor_err", {31'b0, resp_err}, 32'd0);
    step();
    chk("xor_after_valid", {31'b0, resp_valid}, 32'd0);
    chk("xor_after_ready", {31'b0, req_ready}, 32'd1);
    chk("xor_after_busy", {31'b0, busy}, 32'd0);

    // SRA by 31, both shift step sizes
    op        = 4'b1101;
    A         = 32'h8000_0000;
    B         = 32'd31;
    req_valid = 1'b1;
    vld4      = 1'b1;
    step();
    req_valid = 1'b0;
    vld4      = 1'b0;
    n1    = 0;
    n4    = 0;
    seen4 = 1'b0;
    res4  = 32'h0;
    while (!resp_valid && n1 < 100) begin
      step();
      n1++;
      if (resp_valid_4 && !seen4) begin
        seen4 = 1'b1;
        n4    = n1;
        res4  = result_4;
      end
    end
    chk("sra1_valid", {31'b0, resp_valid}, 32'd1);
    chk("sra1_lat", n1 + 1, 32'd32);
    chk("sra1_result", result, 32'hFFFF_FFFF);
    chk("sra4_seen", {31'b0, seen4}, 32'd1);
    chk("sra4_lat", n4 + 1, 32'd9);
    chk("sra4_result", res4, 32'hFFFF_FFFF);
    step();
    chk("sra1_after_valid", {31'b0, resp_valid}, 32'd0);

    // Zero-amount shift
    issue(4'b0001, 32'h1234_5678, 32'h0);
    wait_resp("sll0", lat);
    chk("sll0_lat", lat, 32'd2);
    chk("sll0_result", result, 32'h1234_5678);
    step();

    // SRL by 4
    issue(4'b0101, 32'h8000_0000, 32'd4);
    wait_resp("srl4", lat);
    chk("srl4_lat", lat, 32'd5);
    chk("srl4_result", result, 32'h0800_0000);
    step();

    // SLT / SLTU with -1 vs 1
    issue(4'b0010, 32'hFFFF_FFFF, 32'h1);
    wait_resp("slt", lat);
    chk("slt_result", result, 32'h1);
    step();
    issue(4'b0011, 32'hFFFF_FFFF, 32'h1);
    wait_resp("sltu", lat);
    chk("sltu_result", result, 32'h0);
    step();

    // ADD and SUB wrap
    issue(4'b0000, 32'hFFFF_FFFF, 32'h2);
    wait_resp("add_wrap", lat);
    chk("add_wrap_result", result, 32'h1);
    step();
    issue(4'b1000, 32'h0, 32'h1);
    wait_resp("sub_wrap", lat);
    chk("sub_wrap_result", result, 32'hFFFF_FFFF);
    step();

    // OR
    issue(4'b0110, 32'hF000_000F, 32'h0F00_00F0);
    wait_resp("or", lat);
    chk("or_result", result, 32'hFF00_00FF);
    step();

    // Backpressure with changing inputs and req_valid held in DONE
    resp_ready = 1'b0;
    issue(4'b0111, 32'hF0F0_F0F0, 32'hFF00_FF00);
    wait_resp("bp", lat);
    chk("bp_lat", lat, 32'd2);
    chk("bp_result", result, 32'hF000_F000);
    for (int k = 0; k < 5; k++) begin
      op        = 4'b0000;
      A         = 32'(k);
      B         = $urandom;
      req_valid = 1'b1;
      step();
      chk("bp_hold_result", result, 32'hF000_F000);
      chk("bp_hold_ready", {31'b0, req_ready}, 32'd0);
      chk("bp_hold_valid", {31'b0, resp_valid}, 32'd1);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    step();
    chk("bp_release_valid", {31'b0, resp_valid}, 32'd0);
    chk("bp_release_ready", {31'b0, req_ready}, 32'd1);
    step();
    chk("bp_single_valid", {31'b0, resp_valid}, 32'd0);
    chk("bp_idle_busy", {31'b0, busy}, 32'd0);

    // Illegal op
    issue(4'b1111, 32'd5, 32'd7);
    wait_resp("ill", lat);
    chk("ill_lat", lat, 32'd2);
    chk("ill_result", result, 32'h0);
    chk("ill_err", {31'b0, resp_err}, 32'd1);
    step();
    chk("ill_err_cleared", {31'b0, resp_err}, 32'd0);
    chk("ill_valid_cleared", {31'b0, resp_valid}, 32'd0);

    // Reset during SHIFT cycle 5 of SLL by 20
    issue(4'b0001, 32'h1, 32'd20);
    step();
    step();
    step();
    step();
    chk("rs_busy_before", {31'b0, busy}, 32'd1);
    chk("rs_valid_before", {31'b0, resp_valid}, 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rs_valid", {31'b0, resp_valid}, 32'd0);
    chk("rs_busy", {31'b0, busy}, 32'd0);
    chk("rs_req_ready", {31'b0, req_ready}, 32'd1);
    step();
    rst_n = 1'b1;
    hits = 0;
    for (int k = 0; k < 25; k++) begin
      step();
      if (resp_valid) hits++;
    end
    chk("rs_no_response", hits, 32'd0);
    issue(4'b0000, 32'd3, 32'd4);
    wait_resp("rs_add", lat);
    chk("rs_add_lat", lat, 32'd2);
    chk("rs_add_result", result, 32'd7);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
